// File: rtl/mem_bus_demux_pkg.sv
// Shared definitions for the CPU load/store demux: FSM states and default widths/base.
package mem_bus_demux_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;

  // Addresses at or above this value belong to the MMIO block.
  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_bus_demux_mux.sv
// Two-way data mux picking the response word of the selected target.
module mem_bus_demux_mux #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] dout_c
);

  // sel=0 picks in0, sel=1 picks in1
  always_comb begin
    dout_c = sel ? in1 : in0;
  end

endmodule

// File: rtl/mem_bus_demux.sv
// Routes a single CPU request to data memory (t0) or MMIO (t1) and returns its response.
module mem_bus_demux
  import mem_bus_demux_pkg::*;
#(
  parameter int unsigned          WIDTH     = DATA_W_DEF,
  parameter int unsigned          ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]    MMIO_BASE = ADDR_W'(MMIO_BASE_DEF)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [WIDTH-1:0]  cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [WIDTH-1:0]  cpu_rsp_rdata,

  output logic              t0_req_valid,
  input  logic              t0_req_ready,
  output logic              t0_req_we,
  output logic [ADDR_W-1:0] t0_req_addr,
  output logic [WIDTH-1:0]  t0_req_wdata,
  input  logic              t0_rsp_valid,
  input  logic [WIDTH-1:0]  t0_rsp_rdata,

  output logic              t1_req_valid,
  input  logic              t1_req_ready,
  output logic              t1_req_we,
  output logic [ADDR_W-1:0] t1_req_addr,
  output logic [WIDTH-1:0]  t1_req_wdata,
  input  logic              t1_rsp_valid,
  input  logic [WIDTH-1:0]  t1_rsp_rdata
);

  state_e              state_q, state_d;
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic                sel_q,   sel_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic [WIDTH-1:0]    mux_rdata_c;

  // Response data of whichever target the captured request went to
  mem_bus_demux_mux #(
    .WIDTH (WIDTH)
  ) u_rsp_mux (
    .sel    (sel_q),
    .in0    (t0_rsp_rdata),
    .in1    (t1_rsp_rdata),
    .dout_c (mux_rdata_c)
  );

  // State and captured-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic and handshake outputs; captured regs only change on accept or response
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    sel_d         = sel_q;
    rdata_d       = rdata_q;
    cpu_req_ready = 1'b0;
    cpu_rsp_valid = 1'b0;
    t0_req_valid  = 1'b0;
    t1_req_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          we_d    = cpu_req_we;
          addr_d  = cpu_req_addr;
          wdata_d = cpu_req_wdata;
          sel_d   = (cpu_req_addr >= MMIO_BASE);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        t0_req_valid = ~sel_q;
        t1_req_valid = sel_q;
        if (sel_q ? t1_req_ready : t0_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Only the selected target's response counts; stores return zero
        if (sel_q ? t1_rsp_valid : t0_rsp_valid) begin
          rdata_d = we_q ? '0 : mux_rdata_c;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cpu_rsp_valid = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request payload goes to both targets; only valid is steered
  assign t0_req_we     = we_q;
  assign t0_req_addr   = addr_q;
  assign t0_req_wdata  = wdata_q;
  assign t1_req_we     = we_q;
  assign t1_req_addr   = addr_q;
  assign t1_req_wdata  = wdata_q;
  assign cpu_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_demux.sv
// Scoreboard bench for mem_bus_demux: random and directed requests, behavioural targets.
module tb_mem_bus_demux;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr, cpu_req_wdata;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        t0_req_valid, t0_req_we, t1_req_valid, t1_req_we;
  logic [31:0] t0_req_addr, t0_req_wdata, t1_req_addr, t1_req_wdata;

  logic [1:0]  t_ready      = 2'b00;
  logic [1:0]  t_rsp_valid  = 2'b00;
  logic [31:0] t_rsp_rdata [2] = '{32'h0, 32'h0};

  mem_bus_demux dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .t0_req_valid  (t0_req_valid),
    .t0_req_ready  (t_ready[0]),
    .t0_req_we     (t0_req_we),
    .t0_req_addr   (t0_req_addr),
    .t0_req_wdata  (t0_req_wdata),
    .t0_rsp_valid  (t_rsp_valid[0]),
    .t0_rsp_rdata  (t_rsp_rdata[0]),
    .t1_req_valid  (t1_req_valid),
    .t1_req_ready  (t_ready[1]),
    .t1_req_we     (t1_req_we),
    .t1_req_addr   (t1_req_addr),
    .t1_req_wdata  (t1_req_wdata),
    .t1_rsp_valid  (t_rsp_valid[1]),
    .t1_rsp_rdata  (t_rsp_rdata[1])
  );

  typedef struct {
    int          tgt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req_q [$];
  logic [31:0] exp_rsp_q [$];
  logic [31:0] tdata0_q  [$];
  logic [31:0] tdata1_q  [$];

  int n_checks = 0;
  int n_fail   = 0;

  // Target behaviour knobs (-1 = random)
  int fixed_hold [2] = '{-1, -1};
  int fixed_rsp  [2] = '{-1, -1};
  int stray_req  [2] = '{0, 0};
  int stray_done [2] = '{0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no completion, expected completion", nm);
  endtask

  // Behavioural targets: random ready stalls, random response delay, stray responses when idle
  logic [1:0]  busy   = 2'b00;
  logic [1:0]  in_req = 2'b00;
  int          hold    [2] = '{0, 0};
  int          rsp_cnt [2] = '{0, 0};
  logic [31:0] busy_data [2] = '{32'h0, 32'h0};
  logic        tv, twe, tother;
  logic [31:0] taddr, twd;
  req_t        te;

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      tv     = (n == 0) ? t0_req_valid : t1_req_valid;
      tother = (n == 0) ? t1_req_valid : t0_req_valid;
      twe    = (n == 0) ? t0_req_we    : t1_req_we;
      taddr  = (n == 0) ? t0_req_addr  : t1_req_addr;
      twd    = (n == 0) ? t0_req_wdata : t1_req_wdata;
      t_rsp_valid[n] = 1'b0;
      if (busy[n]) begin
        if (rsp_cnt[n] == 0) begin
          t_rsp_valid[n] = 1'b1;
          t_rsp_rdata[n] = busy_data[n];
          busy[n]        = 1'b0;
        end else begin
          rsp_cnt[n]--;
        end
      end else if (stray_req[n] != stray_done[n] || $urandom_range(7) == 0) begin
        stray_done[n]  = stray_req[n];
        t_rsp_valid[n] = 1'b1;
        t_rsp_rdata[n] = $urandom;
      end
      if (tv && !busy[n]) begin
        if (!in_req[n]) begin
          in_req[n] = 1'b1;
          hold[n]   = (fixed_hold[n] >= 0) ? fixed_hold[n] : int'($urandom_range(3));
        end
        t_ready[n] = (hold[n] == 0);
        if (hold[n] > 0) hold[n]--;
      end else begin
        t_ready[n] = 1'($urandom_range(1));
      end
      if (tv && t_ready[n]) begin
        in_req[n] = 1'b0;
        if (exp_req_q.size() == 0) begin
          fail("req_unexpected");
        end else begin
          te = exp_req_q.pop_front();
          chk("req_target", 32'(n), 32'(te.tgt));
          chk("req_we", 32'(twe), 32'(te.we));
          chk("req_addr", taddr, te.addr);
          chk("req_wdata", twd, te.wdata);
          chk("req_other_valid", 32'(tother), 32'h0);
        end
        if (twe) begin
          busy_data[n] = $urandom | 32'h1;
        end else if (n == 0 && tdata0_q.size() != 0) begin
          busy_data[n] = tdata0_q.pop_front();
        end else if (n == 1 && tdata1_q.size() != 0) begin
          busy_data[n] = tdata1_q.pop_front();
        end else begin
          busy_data[n] = 32'hBAD0_0BAD;
        end
        busy[n]    = 1'b1;
        rsp_cnt[n] = (fixed_rsp[n] >= 0) ? fixed_rsp[n] : int'($urandom_range(3));
      end
    end
  end

  // Response monitor: every cpu_rsp_valid pulse retires the oldest expected response
  logic [31:0] exp_rd;
  always @(negedge clk) begin
    if (cpu_rsp_valid) begin
      if (exp_rsp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got cpu_rsp_valid rdata %h, expected no response", cpu_rsp_rdata);
      end else begin
        exp_rd = exp_rsp_q.pop_front();
        chk("rsp_rdata", cpu_rsp_rdata, exp_rd);
      end
    end
  end

  // Issue one request (called at a negedge); returns at the negedge after acceptance, valid still high
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata);
    req_t r;
    bit   acc;
    r.tgt   = (addr >= MMIO_BASE) ? 1 : 0;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    exp_req_q.push_back(r);
    exp_rsp_q.push_back(we ? 32'h0 : rdata);
    if (!we) begin
      if (r.tgt == 1) tdata1_q.push_back(rdata);
      else            tdata0_q.push_back(rdata);
    end
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    acc = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) begin
      if (cpu_req_ready) acc = 1'b1;
      @(negedge clk);
    end
    if (!acc) fail("accept_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_rsp_q.size() != 0; i++) @(negedge clk);
    if (exp_rsp_q.size() != 0) begin
      fail("drain_timeout");
      exp_rsp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst           = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 32'h0;
    cpu_req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_req_ready", 32'(cpu_req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(cpu_rsp_valid), 32'h0);
    chk("rst_rsp_rdata", cpu_rsp_rdata, 32'h0);
    chk("rst_t0_valid", 32'(t0_req_valid), 32'h0);
    chk("rst_t1_valid", 32'(t1_req_valid), 32'h0);
    chk("rst_t0_addr", t0_req_addr, 32'h0);
    chk("rst_t1_wdata", t1_req_wdata, 32'h0);
    chk("rst_t0_we", 32'(t0_req_we), 32'h0);

    // Best-case load to data memory, cycle-exact
    fixed_hold = '{0, 0};
    fixed_rsp  = '{0, 0};
    do_req(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);
    cpu_req_valid = 1'b0;
    chk("lat_c1_t0_valid", 32'(t0_req_valid), 32'h1);
    chk("lat_c1_t1_valid", 32'(t1_req_valid), 32'h0);
    @(negedge clk);
    chk("lat_c2_rsp_valid", 32'(cpu_rsp_valid), 32'h0);
    @(negedge clk);
    chk("lat_c3_rsp_valid", 32'(cpu_rsp_valid), 32'h1);
    @(negedge clk);
    chk("lat_c4_req_ready", 32'(cpu_req_ready), 32'h1);
    drain();

    // Store at the MMIO base goes to t1, returns zero
    do_req(1'b1, 32'hFFFF_0000, 32'h1234_5678, 32'h0);
    cpu_req_valid = 1'b0;
    drain();

    // Just below the MMIO base stays on t0
    do_req(1'b0, 32'hFFFE_FFFC, 32'h0, 32'hCAFE_F00D);
    cpu_req_valid = 1'b0;
    drain();

    // t1 stalls ready for 5 cycles; stray t0 response during WAIT
    fixed_hold[1] = 5;
    fixed_rsp[1]  = 4;
    do_req(1'b0, 32'hFFFF_0010, 32'h5555_AAAA, 32'h600D_D00D);
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_t1_valid", 32'(t1_req_valid), 32'h1);
      chk("stall_t0_valid", 32'(t0_req_valid), 32'h0);
      chk("stall_req_ready", 32'(cpu_req_ready), 32'h0);
      chk("stall_addr", t1_req_addr, 32'hFFFF_0010);
      chk("stall_wdata", t1_req_wdata, 32'h5555_AAAA);
      @(negedge clk);
    end
    @(negedge clk);
    stray_req[0]++;
    drain();

    // Reset while waiting for a slow t0 response drops the transaction
    fixed_hold[0] = 0;
    fixed_rsp[0]  = 10;
    do_req(1'b0, 32'h0000_0100, 32'h0, 32'h1111_2222);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", 32'(cpu_req_ready), 32'h1);
    chk("midrst_t0_valid", 32'(t0_req_valid), 32'h0);
    chk("midrst_t1_valid", 32'(t1_req_valid), 32'h0);
    chk("midrst_rsp_valid", 32'(cpu_rsp_valid), 32'h0);
    chk("midrst_pending", 32'(exp_rsp_q.size()), 32'h1);
    exp_rsp_q.delete();
    repeat (15) @(negedge clk);
    fixed_rsp[0] = -1;
    do_req(1'b0, 32'h0000_0104, 32'h0, 32'h3333_4444);
    cpu_req_valid = 1'b0;
    drain();

    // Back-to-back with valid held high
    fixed_hold = '{-1, -1};
    fixed_rsp  = '{-1, -1};
    do_req(1'b0, 32'h0000_0200, 32'h0, 32'hA1A1_A1A1);
    do_req(1'b1, 32'hFFFF_0020, 32'h7777_8888, 32'h0);
    do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 32'hB2B2_B2B2);
    cpu_req_valid = 1'b0;
    drain();

    // Random traffic around the MMIO boundary
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(3))
        0:       a = $urandom;
        1:       a = MMIO_BASE + 32'($urandom_range(64));
        2:       a = MMIO_BASE - 32'($urandom_range(1, 64));
        default: a = 32'($urandom_range(4095));
      endcase
      do_req(1'($urandom_range(1)), a, $urandom, $urandom);
      if ($urandom_range(1) == 0) begin
        cpu_req_valid = 1'b0;
        repeat ($urandom_range(3)) @(negedge clk);
      end
    end
    cpu_req_valid = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("end_req_queue", 32'(exp_req_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
